adc_cfg_serializer: RTL and testbench



---
 rtl/adc_cfg_pkg.sv | 40 ++++
 rtl/adc_cfg_rom.sv | 12 +
 rtl/adc_cfg_serializer.sv | 164 ++++++++++++++++
 tb/tb_adc_cfg_serializer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_cfg_pkg.sv
// Shared types and the default ADC configuration table for the serial config path.
// Each table entry holds an 8-bit register address and 16-bit data, sent MSB first.
package adc_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [7:0] ADDR_RST      = 8'h00;
  localparam logic [7:0] ADDR_PWRDN    = 8'h0F;
  localparam logic [7:0] ADDR_TEST_PAT = 8'h25;
  localparam logic [7:0] ADDR_42       = 8'h42;
  localparam logic [7:0] ADDR_45       = 8'h45;
  localparam logic [7:0] ADDR_LVDS_CFG = 8'h46;

  // Entry 0 is a known pattern so the wire format can be recognised on a scope.
  localparam logic [23:0] CFG_TABLE [0:15] = '{
    {8'h0A,         16'h5C3F},
    {ADDR_RST,      16'h0001},
    {ADDR_PWRDN,    16'h0000},
    {ADDR_TEST_PAT, 16'h0000},
    {ADDR_42,       16'h8000},
    {ADDR_45,       16'h0004},
    {ADDR_LVDS_CFG, 16'hC000},
    {ADDR_PWRDN,    16'h0200},
    {ADDR_TEST_PAT, 16'h0040},
    {ADDR_42,       16'h0000},
    {ADDR_45,       16'h0000},
    {ADDR_LVDS_CFG, 16'h8801},
    {ADDR_PWRDN,    16'h0000},
    {ADDR_TEST_PAT, 16'h0000},
    {ADDR_42,       16'h0000},
    {ADDR_45,       16'h0000}
  };

endpackage

// File: rtl/adc_cfg_rom.sv
// Combinational index -> configuration word lookup; swap the table here per board revision.
// Zero latency, no flow control.
module adc_cfg_rom
  import adc_cfg_pkg::*;
(
  input  logic [3:0]  idx,
  output logic [23:0] word
);

  assign word = CFG_TABLE[idx];

endmodule

// File: rtl/adc_cfg_serializer.sv
// Shifts the ADC configuration table out on CSB/SCLK/SDATA while ADC_INIT is held, then flags INIT_DONE.
// All outputs registered (one cycle after the sampling edge); an ADC_INIT drop finishes the current word and gap first.
module adc_cfg_serializer
  import adc_cfg_pkg::*;
#(
  parameter int NUM_WORDS = 8,
  parameter int WORD_W    = 24,
  parameter int CLK_DIV   = 4,
  parameter int GAP       = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ADC_INIT,
  output logic       INIT_DONE,
  output logic       BUSY,
  output logic       ADC_CSB,
  output logic       ADC_SCLK,
  output logic       ADC_SDATA,
  output logic [3:0] WORD_IDX
);

  localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GC_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int BC_W = $clog2(WORD_W + 1);
  localparam logic [HC_W-1:0] HC_LAST  = HC_W'(CLK_DIV - 1);
  localparam logic [GC_W-1:0] GC_LAST  = GC_W'(GAP - 1);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(WORD_W);
  localparam logic [3:0]      IDX_LAST = 4'(NUM_WORDS - 1);

  state_t              state, state_nxt;
  logic [HC_W-1:0]     hcnt, hcnt_nxt;
  logic [GC_W-1:0]     gcnt, gcnt_nxt;
  logic [BC_W-1:0]     bcnt, bcnt_nxt;
  logic [WORD_W-1:0]   shreg, shreg_nxt;
  logic                abort, abort_nxt;
  logic                csb_nxt, sclk_nxt, sdata_nxt, done_nxt, busy_nxt;
  logic [3:0]          idx_nxt;
  logic [3:0]          rom_idx;
  logic [23:0]         rom_word;

  assign rom_idx = (state == S_IDLE) ? 4'd0 : WORD_IDX + 4'd1;

  adc_cfg_rom u_rom (
    .idx  (rom_idx),
    .word (rom_word)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      hcnt      <= '0;
      gcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      abort     <= 1'b0;
      ADC_CSB   <= 1'b1;
      ADC_SCLK  <= 1'b0;
      ADC_SDATA <= 1'b0;
      INIT_DONE <= 1'b0;
      BUSY      <= 1'b0;
      WORD_IDX  <= 4'd0;
    end else begin
      state     <= state_nxt;
      hcnt      <= hcnt_nxt;
      gcnt      <= gcnt_nxt;
      bcnt      <= bcnt_nxt;
      shreg     <= shreg_nxt;
      abort     <= abort_nxt;
      ADC_CSB   <= csb_nxt;
      ADC_SCLK  <= sclk_nxt;
      ADC_SDATA <= sdata_nxt;
      INIT_DONE <= done_nxt;
      BUSY      <= busy_nxt;
      WORD_IDX  <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (ADC_INIT) state_nxt = S_SETUP;
      S_SETUP: if (hcnt == HC_LAST) state_nxt = S_SHIFT;
      S_SHIFT: if (hcnt == HC_LAST && ADC_SCLK && bcnt == BC_LAST) state_nxt = S_GAP;
      S_GAP: begin
        if (gcnt == GC_LAST) begin
          if (abort || !ADC_INIT)     state_nxt = S_IDLE;
          else if (WORD_IDX < IDX_LAST) state_nxt = S_SETUP;
          else                        state_nxt = S_DONE;
        end
      end
      S_DONE:  if (!ADC_INIT) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    hcnt_nxt  = hcnt;
    gcnt_nxt  = gcnt;
    bcnt_nxt  = bcnt;
    shreg_nxt = shreg;
    abort_nxt = abort;
    csb_nxt   = ADC_CSB;
    sclk_nxt  = ADC_SCLK;
    sdata_nxt = ADC_SDATA;
    idx_nxt   = WORD_IDX;
    done_nxt  = (state_nxt == S_DONE);
    busy_nxt  = (state_nxt inside {S_SETUP, S_SHIFT, S_GAP});
    unique case (state)
      S_IDLE: begin
        abort_nxt = 1'b0;
        if (state_nxt == S_SETUP) begin
          idx_nxt   = 4'd0;
          shreg_nxt = WORD_W'(rom_word);
          sdata_nxt = shreg_nxt[WORD_W-1];
          csb_nxt   = 1'b0;
          sclk_nxt  = 1'b0;
          hcnt_nxt  = '0;
          bcnt_nxt  = '0;
        end
      end
      S_SETUP: begin
        if (!ADC_INIT) abort_nxt = 1'b1;
        hcnt_nxt = (hcnt == HC_LAST) ? '0 : hcnt + 1'b1;
      end
      S_SHIFT: begin
        if (!ADC_INIT) abort_nxt = 1'b1;
        if (hcnt == HC_LAST) begin
          hcnt_nxt = '0;
          if (!ADC_SCLK) begin
            sclk_nxt = 1'b1;
            bcnt_nxt = bcnt + 1'b1;
          end else if (state_nxt == S_GAP) begin
            // Closing SCLK fall coincides with CSB release.
            sclk_nxt  = 1'b0;
            csb_nxt   = 1'b1;
            sdata_nxt = 1'b0;
            gcnt_nxt  = '0;
          end else begin
            sclk_nxt  = 1'b0;
            shreg_nxt = shreg << 1;
            sdata_nxt = shreg_nxt[WORD_W-1];
          end
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      S_GAP: begin
        if (!ADC_INIT) abort_nxt = 1'b1;
        if (gcnt != GC_LAST) begin
          gcnt_nxt = gcnt + 1'b1;
        end else if (state_nxt == S_SETUP) begin
          idx_nxt   = WORD_IDX + 4'd1;
          shreg_nxt = WORD_W'(rom_word);
          sdata_nxt = shreg_nxt[WORD_W-1];
          csb_nxt   = 1'b0;
          hcnt_nxt  = '0;
          bcnt_nxt  = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_adc_cfg_serializer.sv
// Randomised bench for adc_cfg_serializer: a scoreboard of expected serial words fed by the stimulus,
// drained by a wire-level monitor, plus cycle-exact CSB/BUSY/INIT_DONE checks from an arithmetic timing model.
module tb_adc_cfg_serializer;
  import adc_cfg_pkg::*;

  localparam int NW  = 3;
  localparam int WW  = 24;
  localparam int CD  = 2;
  localparam int GP  = 4;
  localparam int LOW = CD + 2 * CD * WW;  // CSB-low cycles per word
  localparam int WP  = LOW + GP;          // word period
  localparam int SEQ = NW * WP;

  typedef struct {
    logic [23:0] word;
    logic [3:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ADC_INIT = 1'b0;
  logic       INIT_DONE, BUSY, ADC_CSB, ADC_SCLK, ADC_SDATA;
  logic [3:0] WORD_IDX;

  adc_cfg_serializer #(
    .NUM_WORDS (NW),
    .WORD_W    (WW),
    .CLK_DIV   (CD),
    .GAP       (GP)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ADC_INIT  (ADC_INIT),
    .INIT_DONE (INIT_DONE),
    .BUSY      (BUSY),
    .ADC_CSB   (ADC_CSB),
    .ADC_SCLK  (ADC_SCLK),
    .ADC_SDATA (ADC_SDATA),
    .WORD_IDX  (WORD_IDX)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got 0x%0h need 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Timing model: sample n counts edges after ADC_INIT is raised; sample 1 is the first registered response.
  function automatic logic exp_csb(input int n, input int nw);
    if (n < 1 || n > nw * WP) return 1'b1;
    return ((n - 1) % WP) >= LOW;
  endfunction

  function automatic logic exp_busy(input int n, input int nw);
    return (n >= 1) && (n <= nw * WP);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_cycle(input int n, input int nw, input logic may_finish);
    logic c;
    c = exp_csb(n, nw);
    chk("csb_timing", 32'(ADC_CSB), 32'(c));
    chk("busy_timing", 32'(BUSY), 32'(exp_busy(n, nw)));
    chk("init_done_timing", 32'(INIT_DONE), 32'(may_finish && n > nw * WP));
    if (!c) chk("word_idx_timing", 32'(WORD_IDX), 32'((n - 1) / WP));
  endtask

  task automatic push_words(input int nw);
    for (int w = 0; w < nw; w++) exp_q.push_back('{word: CFG_TABLE[w], idx: 4'(w)});
  endtask

  task automatic run_full();
    push_words(NW);
    ADC_INIT = 1'b1;
    for (int n = 1; n <= SEQ + 1; n++) begin
      tick();
      check_cycle(n, NW, 1'b1);
    end
  endtask

  task automatic handshake();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("done_hold_csb", 32'(ADC_CSB), 32'd1);
      chk("done_hold_flag", 32'(INIT_DONE), 32'd1);
    end
    ADC_INIT = 1'b0;
    tick();
    chk("done_release_flag", 32'(INIT_DONE), 32'd0);
    chk("done_release_busy", 32'(BUSY), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_abort(input int drop_at);
    push_words(2);
    ADC_INIT = 1'b1;
    for (int n = 1; n <= 2 * WP + 30; n++) begin
      tick();
      check_cycle(n, 2, 1'b0);
      if (n == drop_at) ADC_INIT = 1'b0;
    end
    chk("abort_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_reset(input int rst_at);
    push_words(NW);
    ADC_INIT = 1'b1;
    for (int n = 1; n <= rst_at; n++) begin
      tick();
      check_cycle(n, NW, 1'b1);
    end
    RST = 1'b1;
    ADC_INIT = 1'b0;
    tick();
    chk("rst_csb", 32'(ADC_CSB), 32'd1);
    chk("rst_sclk", 32'(ADC_SCLK), 32'd0);
    chk("rst_sdata", 32'(ADC_SDATA), 32'd0);
    chk("rst_word_idx", 32'(WORD_IDX), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(INIT_DONE), 32'd0);
    RST = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_idle_csb", 32'(ADC_CSB), 32'd1);
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  // Wire-level monitor: reconstructs each word from SDATA at SCLK rises and retires it against the scoreboard.
  int          mcyc = 0;
  logic        in_word = 1'b0;
  logic        prev_csb = 1'b1, prev_sclk = 1'b0, prev_sdata = 1'b0;
  logic [23:0] shw = '0;
  int          nbits = 0, t_fall = 0, t_last = 0;

  always @(negedge CLK) begin
    exp_t e;
    mcyc++;
    if (RST) begin
      in_word = 1'b0;
    end else if (!in_word && prev_csb && !ADC_CSB) begin
      in_word = 1'b1;
      shw     = '0;
      nbits   = 0;
      t_fall  = mcyc;
      t_last  = mcyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: CSB fell with idx=%0d, need no transfer", WORD_IDX);
      end else begin
        chk("word_idx_start", 32'(WORD_IDX), 32'(exp_q[0].idx));
      end
    end else if (in_word) begin
      if (ADC_SCLK && !prev_sclk) begin
        chk("sclk_period", 32'(mcyc - t_last), 32'(2 * CD));
        t_last = mcyc;
        shw    = {shw[22:0], ADC_SDATA};
        nbits++;
      end
      if (ADC_SCLK && prev_sclk) chk("sdata_stable_high", 32'(ADC_SDATA), 32'(prev_sdata));
      if (ADC_CSB) begin
        in_word = 1'b0;
        chk("csb_low_len", 32'(mcyc - t_fall), 32'(LOW));
        chk("bit_count", 32'(nbits), 32'(WW));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("serial_word", 32'(shw), 32'(e.word));
          if (e.idx == 4'd0) chk("word0_pattern", 32'(shw), 32'h000A5C3F);
        end
      end
    end
    if (!RST && ADC_CSB) chk("sclk_idle_low", 32'(ADC_SCLK), 32'd0);
    prev_csb   = ADC_CSB;
    prev_sclk  = ADC_SCLK;
    prev_sdata = ADC_SDATA;
  end

  initial begin
    RST = 1'b1;
    ADC_INIT = 1'b0;
    idle(3);
    chk("reset_csb", 32'(ADC_CSB), 32'd1);
    chk("reset_sclk", 32'(ADC_SCLK), 32'd0);
    chk("reset_sdata", 32'(ADC_SDATA), 32'd0);
    chk("reset_done", 32'(INIT_DONE), 32'd0);
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_word_idx", 32'(WORD_IDX), 32'd0);
    RST = 1'b0;
    idle(2);

    run_full();
    handshake();
    run_full();   // back-to-back: re-raised one cycle after returning to Idle
    handshake();
    idle(5);

    run_abort(WP + 5 + 4 * 10);  // word 1, bit 10
    idle(5);
    repeat (2) begin
      run_abort(int'($urandom_range(WP + 1, 2 * WP)));
      idle(int'($urandom_range(1, 8)));
    end

    run_reset(5 + 4 * 5);  // word 0, bit 5
    run_full();
    handshake();
    repeat (2) begin
      run_reset(int'($urandom_range(1, SEQ)));
      idle(int'($urandom_range(1, 8)));
    end
    run_full();
    handshake();
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
